mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port unified `memory` between the `cpu` instruction-fetch stage and the data-access (MEM) stage. Each side sees a req/ack port. The block decides who owns the memory each transaction, sequences the memory enables with a fixed read latency, and returns the read data. It sits between the pipeline stages and `memory` inside `cpu`. Data accesses have priority, and a starvation guard keeps fetch moving.

## Interface
- `ADDR_WIDTH`, 10, word-address width (1024 words).
- `READ_LATENCY`, 1, cycles from the `mem_en` cycle to valid `mem_rdata` (legal range 1–4).
- `STARVE_LIMIT`, 4, maximum consecutive data grants while a fetch waits (must be ≥1).
- `clk`  in  1  system clock; every register uses the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_req`  in  1  fetch request; held high until `i_ack`.
- `i_addr`  in  ADDR_WIDTH  fetch word address; stable while `i_req` is high.
- `i_ack`  out  1  one-cycle completion pulse for a fetch.
- `i_rdata`  out  32  fetch data; valid only while `i_ack`=1.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1=write, 0=read.
- `d_be`  in  4  byte enables for a write.
- `d_addr`  in  ADDR_WIDTH  data word address.
- `d_wdata`  in  32  write data.
- `d_ack`  out  1  one-cycle completion pulse for a data access.
- `d_rdata`  out  32  read data; valid only while `d_ack`=1.
- `mem_en`, `mem_we`  out  1 each  memory enable and write strobe (registered).
- `mem_be`  out  4  byte enables (registered); 4'b0000 on reads.
- `mem_addr`  out  ADDR_WIDTH  memory address (registered).
- `mem_wdata`  out  32  memory write data (registered).
- `mem_rdata`  in  32  memory read data.

## Operation
- The FSM has three states: IDLE, ACCESS and WAIT.
- IDLE arbitration, when either `*_req`=1:
  - Data wins by default.
  - Fetch wins if only `i_req` is high.
  - Fetch also wins if both are high and `starve_cnt`==STARVE_LIMIT.
  - The winner's request fields are registered onto the `mem_*` outputs, and the FSM moves to ACCESS.
- `starve_cnt` update:
  - Increments on a data grant made while `i_req`=1.
  - Clears on a fetch grant.
  - Clears on any grant made while `i_req`=0.
  - Saturates at STARVE_LIMIT.
- ACCESS (exactly one cycle): `mem_en`=1.
  - On a write, `d_ack`=1 in this cycle and the next state is IDLE.
  - On a read, the next state is WAIT with `lat_cnt`=1.
- WAIT: `mem_en`=0 and `lat_cnt` increments each cycle.
  - When `lat_cnt`==READ_LATENCY, the winner's `*_ack`=1 and the next state is IDLE.
  - The winner's `*_rdata` is wired to `mem_rdata`.
- A requester still holding `*_req` in the cycle after its ack issues a new transaction. The requester may change its address fields in the ack cycle.
- A write never asserts `i_ack`. A fetch never asserts `d_ack`. At most one ack is high in any cycle.

## Timing
- Values at reset (`rst`=1 at an edge), and until the next grant:
  - State is IDLE.
  - `mem_en`, `mem_we`, `i_ack` and `d_ack` are 0.
  - `mem_be`, `mem_addr`, `mem_wdata` and `starve_cnt` are 0.
- Reset mid-transaction:
  - An in-flight read is dropped and no ack is issued.
  - A write already presented in ACCESS may have committed in memory.
  - Requests still held high are re-arbitrated in the first cycle after `rst` falls.
- Read, with the request accepted in IDLE at cycle R:
  - `mem_en` is high in R+1.
  - The ack is in R+1+READ_LATENCY.
  - The earliest next accept is R+2+READ_LATENCY.
- Write accepted at R: `mem_en`/`mem_we` and `d_ack` are high in R+1, and the next accept is at R+2.
- Simultaneous requests in IDLE resolve in the same cycle with no idle gap. The loser's request stays pending; it is never lost.
- `i_rdata` and `d_rdata` are don't-care outside their ack cycle.

## Test plan
- Reset values:
  - Stimulus: hold `rst`=1 for 2 cycles while both requests are high.
  - Response: all outputs 0 during reset; the first grant goes to data 1 cycle after `rst` falls.
- Single fetch, READ_LATENCY=1:
  - Setup: memory word 0x004 holds 0x20080005.
  - Stimulus: `i_req` with `i_addr`=0x004 accepted at cycle R.
  - Response: `mem_en`=1 and `mem_addr`=0x004 at R+1; `i_ack`=1 and `i_rdata`=0x20080005 at R+2.
- Byte-enabled write then read:
  - Stimulus: write `d_be`=4'b0011, `d_wdata`=0xDEADBEEF, addr 0x010 (original contents 0x11223344); then read the same address.
  - Response: `d_ack` in the cycle after accept; the read returns 0x1122BEEF.
- Priority and starvation, STARVE_LIMIT=4:
  - Stimulus: hold `i_req` and `d_req` high continuously.
  - Response: the grant sequence is D,D,D,D,I,D,D,D,D,I; never two acks in the same cycle.
- Read latency, READ_LATENCY=3:
  - Stimulus: fetch accepted at R.
  - Response: `i_ack` at R+4; `mem_en` high only at R+1.
- Reset mid-read:
  - Stimulus: assert `rst` in the WAIT cycle of a fetch.
  - Response: no `i_ack`; the held `i_req` is re-accepted 1 cycle after reset and acked with the correct data.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between the instruction-fetch port (i_*)
//   and the data-access port (d_*). Data accesses win arbitration unless a
//   waiting fetch has already been passed over STARVE_LIMIT times in a row.
//   Memory controls are registered; read data returns READ_LATENCY cycles
//   after the enable cycle and is passed straight through to the owner.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   i_req/i_addr          : fetch request (held until i_ack)
//   i_ack/i_rdata         : fetch completion pulse and data
//   d_req/d_we/d_be/      : data request, write flag, byte enables,
//   d_addr/d_wdata        :   address, write data (held until d_ack)
//   d_ack/d_rdata         : data completion pulse and read data
//   mem_en/mem_we/mem_be/ : registered memory controls
//   mem_addr/mem_wdata    :
//   mem_rdata             : memory read data
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_ack,
  output logic [31:0]           d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  localparam int              SCW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0]  STARVE_MAX = SCW'(STARVE_LIMIT);
  localparam logic [2:0]      LAT_DONE   = 3'(READ_LATENCY);

  state_t                  state_q, state_d;
  logic                    owner_data_q, owner_data_d;  // 1: data port owns the access
  logic [2:0]              lat_q, lat_d;
  logic [SCW-1:0]          starve_q, starve_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_we_q, mem_we_d;
  logic [3:0]              mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic                    grant_fetch;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Read data is only meaningful in the owner's ack cycle, so both ports
  // simply see the memory output.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Fetch wins when it is alone, or when it has been starved long enough.
  assign grant_fetch = i_req && (!d_req || (starve_q == STARVE_MAX));

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    lat_d        = lat_q;
    starve_d     = starve_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_ack        = 1'b0;
    d_ack        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d  = ACCESS;
          mem_en_d = 1'b1;
          if (grant_fetch) begin
            owner_data_d = 1'b0;
            mem_addr_d   = i_addr;
            mem_be_d     = 4'b0000;
            starve_d     = '0;
          end else begin
            owner_data_d = 1'b1;
            mem_addr_d   = d_addr;
            mem_we_d     = d_we;
            mem_be_d     = d_we ? d_be : 4'b0000;
            mem_wdata_d  = d_wdata;
            // Only a grant that overtakes a waiting fetch counts as starvation.
            if (!i_req)
              starve_d = '0;
            else if (starve_q != STARVE_MAX)
              starve_d = starve_q + 1'b1;
          end
        end
      end
      ACCESS: begin
        if (mem_we_q) begin
          // Writes complete as soon as they are presented to the memory.
          d_ack   = !rst;
          state_d = IDLE;
        end else begin
          lat_d   = 3'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == LAT_DONE) begin
          // Acks are suppressed under reset so an in-flight read is dropped.
          i_ack   = !owner_data_q && !rst;
          d_ack   = owner_data_q && !rst;
          state_d = IDLE;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b0;
      lat_q        <= '0;
      starve_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      lat_q        <= lat_d;
      starve_q     <= starve_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a READ_LATENCY=1 instance for most scenarios and
// a READ_LATENCY=3 instance for the latency scenario, each with its own
// memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mem_load = 1'b1;
  int          checks = 0;
  int          errors = 0;

  // Instance with READ_LATENCY=1
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [9:0]  i_addr = '0, d_addr = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_wdata = '0;
  logic        i_ack, d_ack, mem_en, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;

  // Instance with READ_LATENCY=3 (fetch only)
  logic        i_req3 = 1'b0, d_req3 = 1'b0, d_we3 = 1'b0;
  logic [9:0]  i_addr3 = '0, d_addr3 = '0;
  logic [3:0]  d_be3 = '0;
  logic [31:0] d_wdata3 = '0;
  logic        i_ack3, d_ack3, mem_en3, mem_we3;
  logic [31:0] i_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_be3;
  logic [9:0]  mem_addr3;

  mem_arbiter #(.ADDR_WIDTH(10), .READ_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_WIDTH(10), .READ_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_be(d_be3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  function automatic logic [31:0] init_word(int a);
    if (a == 4)  return 32'h2008_0005;
    if (a == 16) return 32'h1122_3344;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory models: data valid READ_LATENCY cycles after the enable cycle.
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] rd1;
  logic [31:0] p3 [3];
  assign mem_rdata  = rd1;
  assign mem_rdata3 = p3[2];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int a = 0; a < 1024; a++) mem1[a] <= init_word(a);
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem1[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_en && !mem_we) rd1 <= mem1[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_load) begin
      for (int a = 0; a < 1024; a++) mem3[a] <= init_word(a);
    end else if (mem_en3 && mem_we3) begin
      for (int b = 0; b < 4; b++)
        if (mem_be3[b]) mem3[mem_addr3][8*b +: 8] <= mem_wdata3[8*b +: 8];
    end
    if (mem_en3 && !mem_we3) p3[0] <= mem3[mem_addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  // Expected memory contents, kept by the bench.
  logic [31:0] ref_mem [1024];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_load = 1'b1;
    i_req = 1'b1; i_addr = 10'h004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010; d_be = 4'hF; d_wdata = 32'hCAFE_F00D;
    for (int k = 0; k < 2; k++) begin
      tick();
      mem_load = 1'b0;
      checks++;
      if ({mem_en, mem_we, i_ack, d_ack} !== 4'b0) begin
        errors++; $display("FAIL reset_ctrl got %b want 0000", {mem_en, mem_we, i_ack, d_ack});
      end
      checks++;
      if ({mem_be, mem_addr, mem_wdata} !== '0) begin
        errors++; $display("FAIL reset_fields got be=%h addr=%h wd=%h want 0", mem_be, mem_addr, mem_wdata);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h010 || mem_be !== 4'h0) begin
      errors++; $display("FAIL reset_first_grant got en=%b we=%b addr=%h be=%h want 1 0 010 0", mem_en, mem_we, mem_addr, mem_be);
    end
    tick();
    checks++;
    if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== 32'h1122_3344) begin
      errors++; $display("FAIL reset_first_ack got d_ack=%b i_ack=%b d_rdata=%h want 1 0 11223344", d_ack, i_ack, d_rdata);
    end
    d_req = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 10'h004) begin
      errors++; $display("FAIL reset_pending_fetch got en=%b addr=%h want 1 004", mem_en, mem_addr);
    end
    tick();
    checks++;
    if (i_ack !== 1'b1 || i_rdata !== 32'h2008_0005) begin
      errors++; $display("FAIL reset_fetch_ack got ack=%b data=%h want 1 20080005", i_ack, i_rdata);
    end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    i_req = 1'b1; i_addr = 10'h004;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 10'h004 || mem_we !== 1'b0 || i_ack !== 1'b0) begin
      errors++; $display("FAIL fetch_access got en=%b addr=%h we=%b ack=%b want 1 004 0 0", mem_en, mem_addr, mem_we, i_ack);
    end
    tick();
    checks++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 32'h2008_0005 || mem_en !== 1'b0) begin
      errors++; $display("FAIL fetch_ack got i_ack=%b d_ack=%b data=%h en=%b want 1 0 20080005 0", i_ack, d_ack, i_rdata, mem_en);
    end
    i_req = 1'b0;
    tick();
    checks++;
    if (i_ack !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL fetch_idle got ack=%b en=%b want 0 0", i_ack, mem_en);
    end
  endtask

  task automatic test_write_read();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF; d_addr = 10'h010;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== 32'hDEAD_BEEF || d_ack !== 1'b1) begin
      errors++; $display("FAIL write_access got en=%b we=%b be=%b wd=%h ack=%b want 1 1 0011 deadbeef 1", mem_en, mem_we, mem_be, mem_wdata, d_ack);
    end
    ref_mem[16] = 32'h1122_BEEF;
    d_we = 1'b0;
    tick();
    checks++;
    if (mem_en !== 1'b0 || d_ack !== 1'b0 || i_ack !== 1'b0) begin
      errors++; $display("FAIL write_next_idle got en=%b d_ack=%b i_ack=%b want 0 0 0", mem_en, d_ack, i_ack);
    end
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b0000) begin
      errors++; $display("FAIL read_access got en=%b we=%b be=%b want 1 0 0000", mem_en, mem_we, mem_be);
    end
    tick();
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== 32'h1122_BEEF) begin
      errors++; $display("FAIL read_back got ack=%b data=%h want 1 1122beef", d_ack, d_rdata);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [9:0] exp_fetch;
    int n;
    exp_fetch = 10'b10_0001_0000;  // bit k set: k-th grant goes to fetch
    n = 0;
    i_req = 1'b1; i_addr = 10'h004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
    for (int k = 0; k < 120 && n < 10; k++) begin
      tick();
      checks++;
      if (i_ack && d_ack) begin
        errors++; $display("FAIL starve_two_acks got i_ack=1 d_ack=1 want at most one");
      end
      if (i_ack || d_ack) begin
        checks++;
        if (i_ack !== exp_fetch[n]) begin
          errors++; $display("FAIL starve_order grant %0d got fetch=%b want %b", n, i_ack, exp_fetch[n]);
        end
        checks++;
        if (i_ack ? (i_rdata !== 32'h2008_0005) : (d_rdata !== init_word(32))) begin
          errors++; $display("FAIL starve_data grant %0d got %h want %h", n, i_ack ? i_rdata : d_rdata,
                             i_ack ? 32'h2008_0005 : init_word(32));
        end
        n++;
        if (n == 10) begin i_req = 1'b0; d_req = 1'b0; end
      end
    end
    checks++;
    if (n != 10) begin
      errors++; $display("FAIL starve_timeout got %0d grants want 10", n);
      i_req = 1'b0; d_req = 1'b0;
    end
    tick();
    tick();
  endtask

  task automatic test_latency3();
    i_req3 = 1'b1; i_addr3 = 10'h004;
    tick();
    checks++;
    if (mem_en3 !== 1'b1 || mem_addr3 !== 10'h004 || i_ack3 !== 1'b0) begin
      errors++; $display("FAIL lat3_access got en=%b addr=%h ack=%b want 1 004 0", mem_en3, mem_addr3, i_ack3);
    end
    for (int k = 2; k <= 3; k++) begin
      tick();
      checks++;
      if (mem_en3 !== 1'b0 || i_ack3 !== 1'b0) begin
        errors++; $display("FAIL lat3_wait R+%0d got en=%b ack=%b want 0 0", k, mem_en3, i_ack3);
      end
    end
    tick();
    checks++;
    if (i_ack3 !== 1'b1 || d_ack3 !== 1'b0 || i_rdata3 !== 32'h2008_0005 || mem_en3 !== 1'b0) begin
      errors++; $display("FAIL lat3_ack got i_ack=%b d_ack=%b data=%h en=%b want 1 0 20080005 0", i_ack3, d_ack3, i_rdata3, mem_en3);
    end
    i_req3 = 1'b0;
    tick();
    checks++;
    if (i_ack3 !== 1'b0) begin
      errors++; $display("FAIL lat3_single_ack got ack=%b want 0", i_ack3);
    end
  endtask

  task automatic test_reset_mid_read();
    i_req = 1'b1; i_addr = 10'h010;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (i_ack !== 1'b0) begin
      errors++; $display("FAIL midrst_ack_dropped got ack=%b want 0", i_ack);
    end
    tick();
    checks++;
    if (i_ack !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 10'h000) begin
      errors++; $display("FAIL midrst_state got ack=%b en=%b addr=%h want 0 0 000", i_ack, mem_en, mem_addr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 10'h010 || i_ack !== 1'b0) begin
      errors++; $display("FAIL midrst_regrant got en=%b addr=%h ack=%b want 1 010 0", mem_en, mem_addr, i_ack);
    end
    tick();
    checks++;
    if (i_ack !== 1'b1 || i_rdata !== 32'h1122_BEEF) begin
      errors++; $display("FAIL midrst_ack got ack=%b data=%h want 1 1122beef", i_ack, i_rdata);
    end
    i_req = 1'b0;
    tick();
  endtask

  // Random traffic against a transaction-level model: the memory is free one
  // cycle after each ack; a free memory grants per the priority/starvation rule.
  task automatic test_random();
    int          exp_i_c, exp_d_c, en_c, free_at, starve;
    logic        ip, dp, dwe, en_we, exp_d_rd;
    logic [9:0]  ia, da, en_addr;
    logic [3:0]  dbe;
    logic [31:0] dwd, exp_i_data, exp_d_data;
    ip = 1'b0; dp = 1'b0; dwe = 1'b0; en_we = 1'b0; exp_d_rd = 1'b0;
    ia = '0; da = '0; en_addr = '0; dbe = '0; dwd = '0;
    exp_i_data = '0; exp_d_data = '0;
    exp_i_c = -1; exp_d_c = -1; en_c = -1; free_at = 0; starve = 0;
    for (int c = 0; c < 500; c++) begin
      tick();
      checks++;
      if (i_ack !== (c == exp_i_c)) begin
        errors++; $display("FAIL rnd_i_ack cycle %0d got %b want %b", c, i_ack, c == exp_i_c);
      end
      if (c == exp_i_c) begin
        checks++;
        if (i_rdata !== exp_i_data) begin
          errors++; $display("FAIL rnd_i_data cycle %0d got %h want %h", c, i_rdata, exp_i_data);
        end
        ip = 1'b0;
      end
      checks++;
      if (d_ack !== (c == exp_d_c)) begin
        errors++; $display("FAIL rnd_d_ack cycle %0d got %b want %b", c, d_ack, c == exp_d_c);
      end
      if (c == exp_d_c) begin
        if (exp_d_rd) begin
          checks++;
          if (d_rdata !== exp_d_data) begin
            errors++; $display("FAIL rnd_d_data cycle %0d got %h want %h", c, d_rdata, exp_d_data);
          end
        end
        dp = 1'b0;
      end
      checks++;
      if (mem_en !== (c == en_c)) begin
        errors++; $display("FAIL rnd_mem_en cycle %0d got %b want %b", c, mem_en, c == en_c);
      end
      if (c == en_c) begin
        checks++;
        if (mem_addr !== en_addr || mem_we !== en_we) begin
          errors++; $display("FAIL rnd_mem_ctl cycle %0d got addr=%h we=%b want %h %b", c, mem_addr, mem_we, en_addr, en_we);
        end
      end
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1'b1; ia = 10'($urandom_range(0, 31));
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1'b1; da = 10'($urandom_range(0, 31)); dwe = 1'($urandom_range(0, 1));
        dbe = 4'($urandom); dwd = $urandom;
      end
      i_req = ip; i_addr = ia;
      d_req = dp; d_addr = da; d_we = dwe; d_be = dbe; d_wdata = dwd;
      if (c >= free_at && (ip || dp)) begin
        en_c = c + 1;
        if (ip && (!dp || starve == 4)) begin
          starve     = 0;
          exp_i_c    = c + 2;
          exp_i_data = ref_mem[ia];
          en_addr    = ia; en_we = 1'b0;
          free_at    = exp_i_c + 1;
        end else begin
          starve  = ip ? ((starve < 4) ? starve + 1 : 4) : 0;
          en_addr = da; en_we = dwe;
          if (dwe) begin
            for (int b = 0; b < 4; b++)
              if (dbe[b]) ref_mem[da][8*b +: 8] = dwd[8*b +: 8];
            exp_d_c  = c + 1;
            exp_d_rd = 1'b0;
          end else begin
            exp_d_c    = c + 2;
            exp_d_rd   = 1'b1;
            exp_d_data = ref_mem[da];
          end
          free_at = exp_d_c + 1;
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) ref_mem[a] = init_word(a);
    test_reset();
    test_single_fetch();
    test_latency3();
    test_write_read();
    test_starvation();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
